// File: rtl/trap_pkg.sv
// Shared types and constants for the trap-entry sequencer.
// Holds the FSM states, tt codes, latch bundle and window addresses.
package trap_pkg;

  localparam int NWINDOWS = 8;
  localparam int CWPW = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WR_L1,
    S_WR_L2,
    S_VECTOR,
    S_ERROR
  } state_t;

  localparam logic [7:0] TT_RESET = 8'h00;
  localparam logic [7:0] TT_IAE   = 8'h01;
  localparam logic [7:0] TT_ILL   = 8'h02;
  localparam logic [7:0] TT_PRIV  = 8'h03;
  localparam logic [7:0] TT_WOVF  = 8'h05;
  localparam logic [7:0] TT_WUNF  = 8'h06;
  localparam logic [7:0] TT_ALIGN = 8'h07;

  localparam logic [2:0] IDX_NONE  = 3'd0;
  localparam logic [2:0] IDX_RESET = 3'd1;

  localparam logic [4:0] RA_L1 = 5'd17;
  localparam logic [4:0] RA_L2 = 5'd18;

  typedef struct packed {
    logic [7:0]      tt;
    logic [31:0]     pc;
    logic [31:0]     npc;
    logic [CWPW-1:0] cwp;
    logic            s;
    logic            rst;
  } trap_lat_t;

  function automatic logic [7:0] idx_to_tt(
    input logic [2:0] idx
  );
    logic [7:0] tt;
    tt = TT_RESET;
    case (idx)
      3'd2:    tt = TT_IAE;
      3'd3:    tt = TT_ILL;
      3'd4:    tt = TT_PRIV;
      3'd5:    tt = TT_WOVF;
      3'd6:    tt = TT_WUNF;
      3'd7:    tt = TT_ALIGN;
      default: tt = TT_RESET;
    endcase
    return tt;
  endfunction

endpackage

// File: rtl/trap_seq_tt_map.sv
// Combinational prioritised-index to trap-type lookup.
// Also reused by the TBR read-back path.
module trap_tt_map
  import trap_pkg::*;
(
  input  logic [2:0] idx,
  output logic [7:0] tt
);

  assign tt = idx_to_tt(idx);

endmodule

// File: rtl/trap_seq.sv
// SPARC V8 trap-entry sequencer: PSR, CWP, %l1/%l2, TBR, redirect.
// Holds the pipeline via busy; traps with ET=0 lock into error mode.
module trap_seq
  import trap_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_req,
  input  logic [2:0]  tt_idx,
  input  logic        psr_et,
  input  logic        psr_s,
  input  logic [2:0]  cwp,
  input  logic [31:0] pc,
  input  logic [31:0] npc,
  input  logic [19:0] tba,
  output logic        busy,
  output logic        psr_we,
  output logic        ps_new,
  output logic        cwp_we,
  output logic [2:0]  cwp_new,
  output logic        tbr_we,
  output logic [7:0]  tbr_tt,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pc_load,
  output logic [31:0] pc_new,
  output logic [31:0] npc_new,
  output logic        error_mode
);

  state_t    state_q, state_d;
  trap_lat_t lat_q;
  logic      accept;
  logic [7:0]  tt_in;
  logic [31:0] vec;
  logic [2:0]  cwp_dec;

  trap_tt_map u_map (
    .idx (tt_idx),
    .tt  (tt_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lat_q.tt  <= tt_in;
        lat_q.pc  <= pc;
        lat_q.npc <= npc;
        lat_q.cwp <= cwp;
        lat_q.s   <= psr_s;
        lat_q.rst <= (tt_idx == IDX_RESET);
      end
    end
  end

  // Window rotation decrements modulo NWINDOWS
  assign cwp_dec = (lat_q.cwp == '0) ? 3'(NWINDOWS - 1)
                                     : lat_q.cwp - 3'd1;

  assign vec = lat_q.rst ? 32'h0
                         : {tba, lat_q.tt, 4'b0000};

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    busy       = 1'b0;
    psr_we     = 1'b0;
    ps_new     = 1'b0;
    cwp_we     = 1'b0;
    cwp_new    = '0;
    tbr_we     = 1'b0;
    tbr_tt     = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    pc_load    = 1'b0;
    pc_new     = '0;
    npc_new    = '0;
    error_mode = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (trap_req && tt_idx != IDX_NONE) begin
          if (tt_idx == IDX_RESET) begin
            accept  = 1'b1;
            state_d = S_VECTOR;
          end else if (!psr_et) begin
            state_d = S_ERROR;
          end else begin
            accept  = 1'b1;
            state_d = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        busy    = 1'b1;
        psr_we  = 1'b1;
        ps_new  = lat_q.s;
        cwp_we  = 1'b1;
        cwp_new = cwp_dec;
        tbr_we  = 1'b1;
        tbr_tt  = lat_q.tt;
        state_d = S_WR_L1;
      end
      S_WR_L1: begin
        busy     = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = RA_L1;
        rf_wdata = lat_q.pc;
        state_d  = S_WR_L2;
      end
      S_WR_L2: begin
        busy     = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = RA_L2;
        rf_wdata = lat_q.npc;
        state_d  = S_VECTOR;
      end
      S_VECTOR: begin
        busy    = 1'b1;
        pc_load = 1'b1;
        pc_new  = vec;
        npc_new = vec + 32'd4;
        // Reset entry skips CAPTURE, so its PSR update lands here
        psr_we  = lat_q.rst;
        ps_new  = lat_q.rst & lat_q.s;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        busy       = 1'b1;
        error_mode = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_seq.sv
// Directed self-checking bench for trap_seq.
// Hand-computed expectations for each trap entry scenario.
module tb_trap_seq;

  logic        clk;
  logic        rst_n;
  logic        trap_req;
  logic [2:0]  tt_idx;
  logic        psr_et;
  logic        psr_s;
  logic [2:0]  cwp;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [19:0] tba;
  logic        busy;
  logic        psr_we;
  logic        ps_new;
  logic        cwp_we;
  logic [2:0]  cwp_new;
  logic        tbr_we;
  logic [7:0]  tbr_tt;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_load;
  logic [31:0] pc_new;
  logic [31:0] npc_new;
  logic        error_mode;

  int n_chk;
  int n_fail;
  int cnt_a;
  int cnt_b;

  trap_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trap_req   (trap_req),
    .tt_idx     (tt_idx),
    .psr_et     (psr_et),
    .psr_s      (psr_s),
    .cwp        (cwp),
    .pc         (pc),
    .npc        (npc),
    .tba        (tba),
    .busy       (busy),
    .psr_we     (psr_we),
    .ps_new     (ps_new),
    .cwp_we     (cwp_we),
    .cwp_new    (cwp_new),
    .tbr_we     (tbr_we),
    .tbr_tt     (tbr_tt),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pc_load    (pc_load),
    .pc_new     (pc_new),
    .npc_new    (npc_new),
    .error_mode (error_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(
    input logic [2:0]  idx,
    input logic        et,
    input logic        s,
    input logic [2:0]  w,
    input logic [31:0] p,
    input logic [31:0] np
  );
    trap_req = 1'b1;
    tt_idx   = idx;
    psr_et   = et;
    psr_s    = s;
    cwp      = w;
    pc       = p;
    npc      = np;
    tick();
    trap_req = 1'b0;
    tt_idx   = 3'd0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    trap_req = 1'b0;
    tt_idx   = 3'd0;
    psr_et   = 1'b1;
    psr_s    = 1'b0;
    cwp      = 3'd0;
    pc       = 32'h0;
    npc      = 32'h0;
    tba      = 20'h40000;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(error_mode), 32'd0);
    check("rst_pcnew", pc_new, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // normal tt_idx=3
    go(3'd3, 1'b1, 1'b0, 3'd2, 32'h1000, 32'h1004);
    pc  = 32'hdead;
    npc = 32'hbeef;
    cwp = 3'd5;
    check("a_busy1", 32'(busy), 32'd1);
    check("a_psrwe", 32'(psr_we), 32'd1);
    check("a_psnew", 32'(ps_new), 32'd0);
    check("a_cwpwe", 32'(cwp_we), 32'd1);
    check("a_cwpnew", 32'(cwp_new), 32'd1);
    check("a_tbrwe", 32'(tbr_we), 32'd1);
    check("a_tbrtt", 32'(tbr_tt), 32'h02);
    tick();
    check("a_l1we", 32'(rf_we), 32'd1);
    check("a_l1addr", 32'(rf_waddr), 32'd17);
    check("a_l1data", rf_wdata, 32'h1000);
    check("a_c2psr", 32'(psr_we), 32'd0);
    tick();
    check("a_l2addr", 32'(rf_waddr), 32'd18);
    check("a_l2data", rf_wdata, 32'h1004);
    tick();
    check("a_pcload", 32'(pc_load), 32'd1);
    check("a_pcnew", pc_new, 32'h40000020);
    check("a_npcnew", npc_new, 32'h40000024);
    check("a_c4rfwe", 32'(rf_we), 32'd0);
    tick();
    check("a_busy5", 32'(busy), 32'd0);
    check("a_pcld5", 32'(pc_load), 32'd0);

    // cwp wrap, tt_idx=5
    tba = 20'h12345;
    go(3'd5, 1'b1, 1'b1, 3'd0, 32'h2000, 32'h2004);
    check("b_cwpnew", 32'(cwp_new), 32'd7);
    check("b_tbrtt", 32'(tbr_tt), 32'h05);
    check("b_psnew", 32'(ps_new), 32'd1);
    tick();
    tick();
    tick();
    check("b_pcnew", pc_new, 32'h12345050);
    tick();

    // idle tt_idx=0 strobe and trap_req while busy
    cnt_a = 0;
    trap_req = 1'b1;
    tt_idx   = 3'd0;
    tick();
    trap_req = 1'b0;
    cnt_a += int'(busy);
    go(3'd4, 1'b1, 1'b0, 3'd3, 32'h3000, 32'h3004);
    cnt_a += int'(pc_load);
    tick();
    cnt_a += int'(pc_load);
    trap_req = 1'b1;
    tt_idx   = 3'd3;
    tick();
    trap_req = 1'b0;
    tt_idx   = 3'd0;
    cnt_a += int'(pc_load);
    for (int i = 0; i < 8; i++) begin
      tick();
      cnt_a += int'(pc_load);
    end
    check("c_onepcld", 32'(cnt_a), 32'd1);
    check("c_idle", 32'(busy), 32'd0);

    // reset trap
    tba = 20'h40000;
    go(3'd1, 1'b1, 1'b0, 3'd4, 32'h5000, 32'h5004);
    check("d_pcload", 32'(pc_load), 32'd1);
    check("d_pcnew", pc_new, 32'h0);
    check("d_npcnew", npc_new, 32'h4);
    check("d_psrwe", 32'(psr_we), 32'd1);
    check("d_busy1", 32'(busy), 32'd1);
    cnt_b = int'(cwp_we) + int'(rf_we);
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt_b += int'(cwp_we) + int'(rf_we);
    end
    check("d_nowr", 32'(cnt_b), 32'd0);
    check("d_busy2", 32'(busy), 32'd0);

    // mid-sequence async reset
    go(3'd3, 1'b1, 1'b0, 3'd2, 32'h1000, 32'h1004);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("e_rfwe", 32'(rf_we), 32'd0);
    check("e_busy", 32'(busy), 32'd0);
    check("e_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    go(3'd3, 1'b1, 1'b0, 3'd2, 32'h1000, 32'h1004);
    check("e_tbrtt", 32'(tbr_tt), 32'h02);
    tick();
    tick();
    tick();
    check("e_pcnew", pc_new, 32'h40000020);
    tick();

    // ET=0 error mode
    go(3'd2, 1'b0, 1'b1, 3'd1, 32'h6000, 32'h6004);
    check("f_err1", 32'(error_mode), 32'd1);
    check("f_busy1", 32'(busy), 32'd1);
    check("f_psrwe", 32'(psr_we), 32'd0);
    cnt_b = 0;
    trap_req = 1'b1;
    tt_idx   = 3'd3;
    psr_et   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt_b += int'(psr_we) + int'(cwp_we);
      cnt_b += int'(rf_we) + int'(pc_load);
      cnt_b += int'(tbr_we);
    end
    trap_req = 1'b0;
    tt_idx   = 3'd0;
    check("f_nostrb", 32'(cnt_b), 32'd0);
    check("f_sticky", 32'(error_mode), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("f_rsterr", 32'(error_mode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("f_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_seq.md
# trap_seq

Trap-entry sequencer sitting directly downstream of the trap-type encoder `tt_Aux`. It consumes the encoder's 3-bit prioritised trap index and runs the SPARC V8 trap-entry sequence as a fixed multi-cycle state machine:
- disable traps and enter supervisor mode;
- rotate CWP to the next window;
- save PC and nPC into %l1 and %l2 of the new window;
- record tt in TBR;
- redirect fetch to the trap vector.

It stalls the pipeline for the duration and enters error mode on a trap taken with ET=0.

## Interface
- NWINDOWS, 8, number of register windows; CWP width is 3.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- trap_req  in  1  one-cycle strobe; tt_idx is valid this cycle.
- tt_idx  in  3  prioritised index from tt_Aux; 0 means no trap.
- psr_et, psr_s  in  1 each  current PSR trap-enable and supervisor bits.
- cwp  in  3  current window pointer.
- pc, npc  in  32 each  PC and nPC of the trapped instruction.
- tba  in  20  TBR trap base address.
- busy  out  1  sequence in progress; doubles as pipeline hold.
- psr_we  out  1  write strobe; sets ET=0, PS=psr_s (latched), S=1.
- ps_new  out  1  value for PSR.PS.
- cwp_we  out  1  write strobe for cwp_new.
- cwp_new  out  3  new window pointer.
- tbr_we  out  1  write strobe for tbr_tt.
- tbr_tt  out  8  trap type to write into TBR.tt.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- pc_load  out  1  fetch redirect strobe.
- pc_new, npc_new  out  32 each  redirect PC and nPC.
- error_mode  out  1  sticky; processor halted.

## Operation
- Index-to-tt mapping:
  - 1→0x00 reset
  - 2→0x01 instruction_access_exception
  - 3→0x02 illegal_instruction
  - 4→0x03 privileged_instruction
  - 5→0x05 window_overflow
  - 6→0x06 window_underflow
  - 7→0x07 mem_address_not_aligned
- States: IDLE, CAPTURE, WR_L1, WR_L2, VECTOR, ERROR.
- IDLE:
  - trap_req with tt_idx=0 is ignored.
  - tt_idx=1 (reset): latch tt and go to VECTOR with pc_new=0. No window rotation, no register writes. psr_we still fires in VECTOR.
  - tt_idx≠0 and psr_et=0 (non-reset): go to ERROR.
  - Otherwise latch tt_idx, pc, npc, cwp and psr_s, then go to CAPTURE.
- CAPTURE: psr_we=1 and ps_new=latched S; cwp_we=1 with cwp_new=(cwp_lat−1) mod NWINDOWS; tbr_we=1.
- WR_L1: rf_we=1, rf_waddr=17, rf_wdata=pc_lat.
- WR_L2: rf_we=1, rf_waddr=18, rf_wdata=npc_lat.
- VECTOR: pc_load=1, pc_new={tba, tt, 4'b0000}, npc_new=pc_new+4; next state IDLE.
- ERROR: error_mode=1 and busy=1; the state exits only on reset.
- trap_req while busy is ignored. tt_Aux prioritisation is upstream; this block performs no arbitration.

## Timing
- Reset (async, rst_n low): state=IDLE, all latched registers 0, every output 0 (including error_mode).
- Strobes are registered-state decodes, each exactly one cycle wide.
- For trap_req sampled at edge 0:
  - CAPTURE strobes in cycle 1.
  - %l1 write in cycle 2.
  - %l2 write in cycle 3.
  - pc_load in cycle 4.
  - busy high in cycles 1–4; a new trap_req is accepted at edge 5 at the earliest.
- Reset trap: busy and pc_load in cycle 1 only.
- ERROR: busy and error_mode rise in cycle 1 and hold.
- CWP wrap: cwp=0 gives cwp_new=NWINDOWS−1 (7).
- Inputs pc, npc, cwp and psr_s are sampled only at acceptance. Later changes do not affect the sequence.
- rst_n asserted mid-sequence aborts immediately with no further strobes. After release the block is in IDLE.

## Structure
- Package trap_pkg holds:
  - the state enum;
  - tt constants;
  - function idx_to_tt(3-bit)→8-bit;
  - register addresses L1=17 and L2=18.
- Sub-module trap_tt_map is the combinational idx→tt lookup, shared with the TBR read-back logic.
- Everything else lives in a single FSM plus a latch register bank.

## Test plan
- Reset: rst_n=0 mid-sequence → all outputs 0 immediately and state IDLE. trap_req=1, tt_idx=3 at the next edge → normal sequence.
- tt_idx=3, psr_et=1, psr_s=0, cwp=2, pc=0x1000, npc=0x1004, tba=0x40000:
  - cycle 1: cwp_new=1, ps_new=0, tbr_tt=0x02;
  - r17←0x1000, r18←0x1004;
  - cycle 4: pc_new=0x40000020, npc_new=0x40000024.
- tt_idx=5, cwp=0 → cwp_new=7, tbr_tt=0x05, pc_new={tba,8'h05,4'h0}.
- tt_idx=2 with psr_et=0 → error_mode=1 from cycle 1 and stays high. Further trap_req produces no strobes until reset.
- trap_req during busy (cycle 2) plus tt_idx=0 strobe in IDLE → both ignored. Exactly one pc_load observed.
- tt_idx=1 → cycle 1 shows pc_load=1, pc_new=0, npc_new=4, psr_we=1; cwp_we=0 and rf_we=0 throughout.
